pic_command_decoder: RTL

Command-word decoder and initialization sequencer for the 8259-compatible interrupt controller. It sits directly downstream of the read/write logic and data bus buffer stage and consumes its one-cycle write strobe, A0 and latched data byte. It steps through the ICW1–ICW4 initialization sequence, then decodes OCW1–OCW3. Its outputs are the mask register, configuration bits and one-cycle command pulses used by the priority resolver, in-service logic and cascade logic.

---
 rtl/pic_pkg.sv | 39 +++
 rtl/pic_ocw2_decode.sv | 46 ++++
 rtl/pic_command_decoder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-compatible command decoder.
package pic_pkg;

    localparam int unsigned DATA_W       = 8;
    localparam int unsigned VBASE_W      = 5;
    localparam int unsigned LEVEL_W      = 3;
    localparam int unsigned ICW4_W       = 5;
    localparam int unsigned ICW1_SEL_BIT = 4;
    localparam int unsigned OCW_SEL_HI   = 4;
    localparam int unsigned OCW_SEL_LO   = 3;

    typedef enum logic [2:0] {
        ST_UNINIT    = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } state_t;

    // OCW2 {R,SL,EOI} command codes
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NSEOI        = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SEOI         = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NSEOI    = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_SEOI     = 3'b111;

    typedef struct packed {
        logic eoi;
        logic eoi_specific;
        logic rotate;
        logic set_prio;
        logic rot_aeoi_set;
        logic rot_aeoi_clr;
    } ocw2_cmd_t;

endpackage

// File: rtl/pic_ocw2_decode.sv
// Combinational map from OCW2 {R,SL,EOI} to pulse enables and rotate-AEOI strobes.
module pic_ocw2_decode
    import pic_pkg::*;
(
    input  logic [2:0] i_code,
    output ocw2_cmd_t  o_cmd_c
);

    always_comb begin
        o_cmd_c = '0;
        case (i_code)
            OCW2_NSEOI: begin
                o_cmd_c.eoi = 1'b1;
            end
            OCW2_SEOI: begin
                o_cmd_c.eoi          = 1'b1;
                o_cmd_c.eoi_specific = 1'b1;
            end
            OCW2_ROT_NSEOI: begin
                o_cmd_c.eoi    = 1'b1;
                o_cmd_c.rotate = 1'b1;
            end
            OCW2_ROT_SEOI: begin
                o_cmd_c.eoi          = 1'b1;
                o_cmd_c.eoi_specific = 1'b1;
                o_cmd_c.rotate       = 1'b1;
            end
            OCW2_SET_PRIO: begin
                o_cmd_c.set_prio = 1'b1;
            end
            OCW2_ROT_AEOI_SET: begin
                o_cmd_c.rot_aeoi_set = 1'b1;
            end
            OCW2_ROT_AEOI_CLR: begin
                o_cmd_c.rot_aeoi_clr = 1'b1;
            end
            OCW2_NOP: begin
                o_cmd_c = '0;
            end
            default: begin
                o_cmd_c = '0;
            end
        endcase
    end

endmodule

// File: rtl/pic_command_decoder.sv
// ICW1-ICW4 initialization sequencer and OCW1-OCW3 decoder; all outputs registered.
module pic_command_decoder
    import pic_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr_strobe,
    input  logic                 i_a0,
    input  logic [DATA_W-1:0]    i_din,
    output logic                 o_init_done,
    output logic                 o_ltim,
    output logic                 o_sngl,
    output logic                 o_ic4,
    output logic [VBASE_W-1:0]   o_vector_base,
    output logic [DATA_W-1:0]    o_cascade_cfg,
    output logic                 o_upm,
    output logic                 o_aeoi,
    output logic                 o_ms,
    output logic                 o_buf,
    output logic                 o_sfnm,
    output logic [DATA_W-1:0]    o_imr,
    output logic                 o_rotate_aeoi,
    output logic                 o_eoi_pulse,
    output logic                 o_eoi_specific,
    output logic                 o_rotate_pulse,
    output logic                 o_set_prio_pulse,
    output logic [LEVEL_W-1:0]   o_ocw2_level,
    output logic                 o_read_isr,
    output logic                 o_poll_pulse,
    output logic                 o_smm
);

    state_t               r_state, w_state_nxt;
    logic                 r_init_done, w_init_done_nxt;
    logic                 r_ltim, w_ltim_nxt;
    logic                 r_sngl, w_sngl_nxt;
    logic                 r_ic4, w_ic4_nxt;
    logic [VBASE_W-1:0]   r_vbase, w_vbase_nxt;
    logic [DATA_W-1:0]    r_cascade, w_cascade_nxt;
    logic [ICW4_W-1:0]    r_icw4, w_icw4_nxt;
    logic [DATA_W-1:0]    r_imr, w_imr_nxt;
    logic                 r_rot_aeoi, w_rot_aeoi_nxt;
    logic                 r_eoi, w_eoi_nxt;
    logic                 r_eoi_spec, w_eoi_spec_nxt;
    logic                 r_rotate, w_rotate_nxt;
    logic                 r_set_prio, w_set_prio_nxt;
    logic [LEVEL_W-1:0]   r_level, w_level_nxt;
    logic                 r_read_isr, w_read_isr_nxt;
    logic                 r_poll, w_poll_nxt;
    logic                 r_smm, w_smm_nxt;

    logic                 w_icw1;
    logic [1:0]           w_ocw_sel;
    ocw2_cmd_t            w_cmd;

    assign w_icw1    = i_wr_strobe && !i_a0 && i_din[ICW1_SEL_BIT];
    assign w_ocw_sel = i_din[OCW_SEL_HI:OCW_SEL_LO];

    pic_ocw2_decode u_ocw2_decode (
        .i_code  (i_din[7:5]),
        .o_cmd_c (w_cmd)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_UNINIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next register values; pulses default low every cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_ltim_nxt      = r_ltim;
        w_sngl_nxt      = r_sngl;
        w_ic4_nxt       = r_ic4;
        w_vbase_nxt     = r_vbase;
        w_cascade_nxt   = r_cascade;
        w_icw4_nxt      = r_icw4;
        w_imr_nxt       = r_imr;
        w_rot_aeoi_nxt  = r_rot_aeoi;
        w_eoi_nxt       = 1'b0;
        w_eoi_spec_nxt  = 1'b0;
        w_rotate_nxt    = 1'b0;
        w_set_prio_nxt  = 1'b0;
        w_level_nxt     = r_level;
        w_read_isr_nxt  = r_read_isr;
        w_poll_nxt      = 1'b0;
        w_smm_nxt       = r_smm;

        if (w_icw1) begin
            w_ltim_nxt     = i_din[3];
            w_sngl_nxt     = i_din[1];
            w_ic4_nxt      = i_din[0];
            w_imr_nxt      = '0;
            w_smm_nxt      = 1'b0;
            w_read_isr_nxt = 1'b0;
            w_rot_aeoi_nxt = 1'b0;
            w_icw4_nxt     = '0;
            w_state_nxt    = ST_WAIT_ICW2;
        end else if (i_wr_strobe) begin
            case (r_state)
                ST_WAIT_ICW2: begin
                    if (i_a0) begin
                        w_vbase_nxt = i_din[DATA_W-1:DATA_W-VBASE_W];
                        if (!r_sngl) begin
                            w_state_nxt = ST_WAIT_ICW3;
                        end else if (r_ic4) begin
                            w_state_nxt = ST_WAIT_ICW4;
                        end else begin
                            w_state_nxt = ST_READY;
                        end
                    end
                end
                ST_WAIT_ICW3: begin
                    if (i_a0) begin
                        w_cascade_nxt = i_din;
                        w_state_nxt   = r_ic4 ? ST_WAIT_ICW4 : ST_READY;
                    end
                end
                ST_WAIT_ICW4: begin
                    if (i_a0) begin
                        w_icw4_nxt  = i_din[ICW4_W-1:0];
                        w_state_nxt = ST_READY;
                    end
                end
                ST_READY: begin
                    if (i_a0) begin
                        w_imr_nxt = i_din;
                    end else if (w_ocw_sel == 2'b00) begin
                        w_level_nxt    = i_din[LEVEL_W-1:0];
                        w_eoi_nxt      = w_cmd.eoi;
                        w_eoi_spec_nxt = w_cmd.eoi_specific;
                        w_rotate_nxt   = w_cmd.rotate;
                        w_set_prio_nxt = w_cmd.set_prio;
                        if (w_cmd.rot_aeoi_set) begin
                            w_rot_aeoi_nxt = 1'b1;
                        end else if (w_cmd.rot_aeoi_clr) begin
                            w_rot_aeoi_nxt = 1'b0;
                        end
                    end else if (w_ocw_sel == 2'b01) begin
                        if (i_din[1]) begin
                            w_read_isr_nxt = i_din[0];
                        end
                        w_poll_nxt = i_din[2];
                        if (i_din[6]) begin
                            w_smm_nxt = i_din[5];
                        end
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end

        w_init_done_nxt = (w_state_nxt == ST_READY);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_init_done <= 1'b0;
            r_ltim      <= 1'b0;
            r_sngl      <= 1'b0;
            r_ic4       <= 1'b0;
            r_vbase     <= '0;
            r_cascade   <= '0;
            r_icw4      <= '0;
            r_imr       <= '0;
            r_rot_aeoi  <= 1'b0;
            r_eoi       <= 1'b0;
            r_eoi_spec  <= 1'b0;
            r_rotate    <= 1'b0;
            r_set_prio  <= 1'b0;
            r_level     <= '0;
            r_read_isr  <= 1'b0;
            r_poll      <= 1'b0;
            r_smm       <= 1'b0;
        end else begin
            r_init_done <= w_init_done_nxt;
            r_ltim      <= w_ltim_nxt;
            r_sngl      <= w_sngl_nxt;
            r_ic4       <= w_ic4_nxt;
            r_vbase     <= w_vbase_nxt;
            r_cascade   <= w_cascade_nxt;
            r_icw4      <= w_icw4_nxt;
            r_imr       <= w_imr_nxt;
            r_rot_aeoi  <= w_rot_aeoi_nxt;
            r_eoi       <= w_eoi_nxt;
            r_eoi_spec  <= w_eoi_spec_nxt;
            r_rotate    <= w_rotate_nxt;
            r_set_prio  <= w_set_prio_nxt;
            r_level     <= w_level_nxt;
            r_read_isr  <= w_read_isr_nxt;
            r_poll      <= w_poll_nxt;
            r_smm       <= w_smm_nxt;
        end
    end

    assign o_init_done      = r_init_done;
    assign o_ltim           = r_ltim;
    assign o_sngl           = r_sngl;
    assign o_ic4            = r_ic4;
    assign o_vector_base    = r_vbase;
    assign o_cascade_cfg    = r_cascade;
    assign o_upm            = r_icw4[0];
    assign o_aeoi           = r_icw4[1];
    assign o_ms             = r_icw4[2];
    assign o_buf            = r_icw4[3];
    assign o_sfnm           = r_icw4[4];
    assign o_imr            = r_imr;
    assign o_rotate_aeoi    = r_rot_aeoi;
    assign o_eoi_pulse      = r_eoi;
    assign o_eoi_specific   = r_eoi_spec;
    assign o_rotate_pulse   = r_rotate;
    assign o_set_prio_pulse = r_set_prio;
    assign o_ocw2_level     = r_level;
    assign o_read_isr       = r_read_isr;
    assign o_poll_pulse     = r_poll;
    assign o_smm            = r_smm;

endmodule
